// File: rtl/predictor_upd_ctrl_pkg.sv
// Shared types, constants and helpers for the branch-predictor update path.
// Holds the controller FSM encoding, the PC width and the ghr->bank mapping
// that both the update scheduler and the predictor read-side select use.
package predictor_upd_ctrl_pkg;

  // Width of a branch PC as carried from EX.
  localparam int ADDR_WIDTH = 32;

  // Counter value a clear write leaves in every entry (weakly-not-taken).
  localparam logic [1:0] PR_CLR_VALUE = 2'b01;

  // Controller states: table clear walk, or normal update draining.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } upd_state_e;

  // Global history selects one of four predictor banks, one-hot.
  function automatic logic [3:0] ghr_to_bank(input logic [1:0] g);
    logic [3:0] b;
    b = 4'b0001 << g;
    return b;
  endfunction

endpackage

// File: rtl/predictor_upd_ctrl_if.sv
// Update/write-port bundle between EX, the update scheduler and the predictor.
// master = EX-side driver of updates/flush/stall; slave = the scheduler.
// All signals are synchronous to the core clock.
interface predictor_upd_ctrl_if #(
  parameter int PC_WIDTH      = predictor_upd_ctrl_pkg::ADDR_WIDTH,
  parameter int PR_ADDR_WIDTH = 8,
  parameter int CNT_WIDTH     = 8
);
  logic                     upd_valid;
  logic                     upd_is_loop;
  logic                     upd_taken;
  logic [PC_WIDTH-1:0]      upd_pc;
  logic                     upd_ready;
  logic                     flush_req;
  logic                     pr_wr_stall;
  logic [1:0]               ghr;
  logic                     pr_wen;
  logic [PR_ADDR_WIDTH-1:0] pr_waddr;
  logic                     pr_wtaken;
  logic                     pr_clr;
  logic [3:0]               pr_bank_sel;
  logic                     flush_busy;
  logic [CNT_WIDTH-1:0]     drop_cnt;

  modport master (
    output upd_valid, upd_is_loop, upd_taken, upd_pc, flush_req, pr_wr_stall,
    input  upd_ready, ghr, pr_wen, pr_waddr, pr_wtaken, pr_clr, pr_bank_sel,
           flush_busy, drop_cnt
  );

  modport slave (
    input  upd_valid, upd_is_loop, upd_taken, upd_pc, flush_req, pr_wr_stall,
    output upd_ready, ghr, pr_wen, pr_waddr, pr_wtaken, pr_clr, pr_bank_sel,
           flush_busy, drop_cnt
  );

endinterface

// File: rtl/predictor_upd_ctrl_fifo.sv
// Synchronous update queue with push/pop/flush and pointer-compare full/empty.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: push while full and pop while empty are ignored.
module pr_upd_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4
) (
  input  logic             cpu_clk,
  input  logic             cpu_rstn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_dat     = r_mem[r_rptr[AW-1:0]];
  assign w_do_push = i_push && !o_full && !i_flush;
  assign w_do_pop  = i_pop && !o_empty && !i_flush;

  // Pointer update; flush discards every queued entry at once.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read once a push has landed.
  always_ff @(posedge cpu_clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_dat;
  end

endmodule

// File: rtl/predictor_upd_ctrl.sv
// Predictor update scheduler: GHR, update queue, drain and clear walk.
// Latency: accepted update reaches the write port 2 edges later when unstalled.
// Backpressure: upd_ready drops when queue is full or clearing; excess updates counted.
module predictor_upd_ctrl
  import predictor_upd_ctrl_pkg::*;
#(
  parameter int ENTRY_NUM     = 256,
  parameter int PR_ADDR_WIDTH = $clog2(ENTRY_NUM),
  parameter int FIFO_DEPTH    = 4,
  parameter int CNT_WIDTH     = 8
) (
  input logic                 cpu_clk,
  input logic                 cpu_rstn,
  predictor_upd_ctrl_if.slave upd_if
);
  localparam int FW = PR_ADDR_WIDTH + 5;
  localparam logic [PR_ADDR_WIDTH-1:0] LAST_IDX = PR_ADDR_WIDTH'(ENTRY_NUM - 1);

  upd_state_e               r_state;
  upd_state_e               w_state_nxt;
  logic [PR_ADDR_WIDTH-1:0] r_idx;
  logic [1:0]               r_ghr;
  logic [CNT_WIDTH-1:0]     r_drop_cnt;
  logic                     r_flush_busy;
  logic                     r_wen;
  logic                     r_clr;
  logic                     r_wtaken;
  logic [PR_ADDR_WIDTH-1:0] r_waddr;
  logic [3:0]               r_bank_sel;

  logic          w_upd_ready;
  logic          w_push;
  logic          w_drop;
  logic          w_pop;
  logic          w_clr_wr;
  logic [FW-1:0] w_push_dat;
  logic [FW-1:0] w_head_dat;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic          w_unused_pc;

  // Only the word-index bits of the PC address the table.
  assign w_unused_pc = ^{upd_if.upd_pc[ADDR_WIDTH-1:PR_ADDR_WIDTH+2], upd_if.upd_pc[1:0]};
  assign w_push_dat  = {upd_if.upd_pc[PR_ADDR_WIDTH+1:2], upd_if.upd_taken, ghr_to_bank(r_ghr)};

  pr_upd_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .cpu_clk  (cpu_clk),
    .cpu_rstn (cpu_rstn),
    .i_push   (w_push),
    .i_dat    (w_push_dat),
    .i_pop    (w_pop),
    .i_flush  (upd_if.flush_req),
    .o_dat    (w_head_dat),
    .o_full   (w_fifo_full),
    .o_empty  (w_fifo_empty)
  );

  // State register.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) r_state <= ST_CLEAR;
    else           r_state <= w_state_nxt;
  end

  // Next state plus accept/drop/drain/clear decisions; flush overrides all.
  always_comb begin
    w_state_nxt = r_state;
    w_upd_ready = 1'b0;
    w_push      = 1'b0;
    w_drop      = 1'b0;
    w_pop       = 1'b0;
    w_clr_wr    = 1'b0;
    if (r_state == ST_RUN) begin
      w_upd_ready = !w_fifo_full;
    end
    if (upd_if.upd_valid && !upd_if.upd_is_loop) begin
      w_push = w_upd_ready && !upd_if.flush_req;
      w_drop = !w_upd_ready || upd_if.flush_req;
    end
    if (upd_if.flush_req) begin
      w_state_nxt = ST_CLEAR;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          w_clr_wr = !upd_if.pr_wr_stall;
          if (w_clr_wr && (r_idx == LAST_IDX)) w_state_nxt = ST_RUN;
        end
        ST_RUN: begin
          w_pop = !w_fifo_empty && !upd_if.pr_wr_stall;
        end
        default: w_state_nxt = ST_CLEAR;
      endcase
    end
  end

  // Clear walk index, restarted by flush and advanced only on a real write.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn)                       r_idx <= '0;
    else if (upd_if.flush_req)           r_idx <= '0;
    else if (w_clr_wr && r_idx == LAST_IDX) r_idx <= '0;
    else if (w_clr_wr)                   r_idx <= r_idx + 1'b1;
  end

  // Global history shifts in each accepted direction; flush zeroes it.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn)             r_ghr <= 2'b00;
    else if (upd_if.flush_req) r_ghr <= 2'b00;
    else if (w_push)           r_ghr <= {r_ghr[0], upd_if.upd_taken};
  end

  // Saturating count of lost non-loop updates; only reset clears it.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn)                      r_drop_cnt <= '0;
    else if (w_drop && !(&r_drop_cnt))  r_drop_cnt <= r_drop_cnt + 1'b1;
  end

  // Busy flag trails the state so it falls the cycle after the last clear write.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) r_flush_busy <= 1'b1;
    else           r_flush_busy <= upd_if.flush_req || (r_state == ST_CLEAR);
  end

  // Registered write port: clear writes in CLEAR, queue head in RUN.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      r_wen      <= 1'b0;
      r_clr      <= 1'b0;
      r_wtaken   <= 1'b0;
      r_waddr    <= '0;
      r_bank_sel <= 4'b0000;
    end else if (w_clr_wr) begin
      r_wen      <= 1'b1;
      r_clr      <= 1'b1;
      r_waddr    <= r_idx;
      r_bank_sel <= 4'b1111;
    end else if (w_pop) begin
      r_wen      <= 1'b1;
      r_clr      <= 1'b0;
      r_waddr    <= w_head_dat[FW-1:5];
      r_wtaken   <= w_head_dat[4];
      r_bank_sel <= w_head_dat[3:0];
    end else begin
      r_wen      <= 1'b0;
      r_clr      <= 1'b0;
    end
  end

  assign upd_if.upd_ready   = w_upd_ready;
  assign upd_if.ghr         = r_ghr;
  assign upd_if.pr_wen      = r_wen;
  assign upd_if.pr_waddr    = r_waddr;
  assign upd_if.pr_wtaken   = r_wtaken;
  assign upd_if.pr_clr      = r_clr;
  assign upd_if.pr_bank_sel = r_bank_sel;
  assign upd_if.flush_busy  = r_flush_busy;
  assign upd_if.drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_predictor_upd_ctrl.sv
// Bench for predictor_upd_ctrl: table vectors, scoreboarded write port,
// hand sequences for queue-full, flush and drop-counter saturation.
module tb_predictor_upd_ctrl;
  import predictor_upd_ctrl_pkg::*;

  logic cpu_clk = 1'b0;
  logic cpu_rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  predictor_upd_ctrl_if #(.PR_ADDR_WIDTH(8), .CNT_WIDTH(8)) upd_if ();

  predictor_upd_ctrl #(
    .ENTRY_NUM(256), .FIFO_DEPTH(4), .CNT_WIDTH(8)
  ) dut (
    .cpu_clk  (cpu_clk),
    .cpu_rstn (cpu_rstn),
    .upd_if   (upd_if)
  );

  always #5 cpu_clk = ~cpu_clk;
  always @(posedge cpu_clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] pc;
    logic        tk;
    logic        lp;
    logic [7:0]  addr;
    logic [3:0]  bank;
    logic [1:0]  ghr_after;
  } vec_t;

  vec_t        vt [7];
  logic [12:0] sb_q [$];
  int          wr_cyc [$];
  logic [1:0]  mghr = 2'b00;
  int          mdrop = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Update-write monitor: every non-clear write must match the scoreboard head.
  always @(negedge cpu_clk) begin
    if (cpu_rstn && upd_if.pr_wen && !upd_if.pr_clr) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual addr %0h required none (cycle %0d)",
                 upd_if.pr_waddr, cyc);
      end else begin
        logic [12:0] e;
        e = sb_q.pop_front();
        wr_cyc.push_back(cyc);
        if ({upd_if.pr_waddr, upd_if.pr_wtaken, upd_if.pr_bank_sel} !== e) begin
          errors++;
          $display("FAIL write_entry actual %0h required %0h (cycle %0d)",
                   {upd_if.pr_waddr, upd_if.pr_wtaken, upd_if.pr_bank_sel}, e, cyc);
        end
      end
    end
  end

  // Drive one update for one cycle; called and returns at a negedge.
  task automatic send_upd(input logic [31:0] pc, input logic tk, input logic lp,
                          input logic exp_acc, input logic [12:0] ent, input bit sb);
    chk("upd_ready", {31'b0, upd_if.upd_ready}, {31'b0, exp_acc});
    upd_if.upd_valid   = 1'b1;
    upd_if.upd_pc      = pc;
    upd_if.upd_taken   = tk;
    upd_if.upd_is_loop = lp;
    if (sb && exp_acc && !lp) sb_q.push_back(ent);
    if (!lp && !exp_acc && mdrop != 255) mdrop++;
    @(negedge cpu_clk);
    upd_if.upd_valid   = 1'b0;
    upd_if.upd_is_loop = 1'b0;
  endtask

  // Update whose expected entry comes from the bench's own ghr model.
  task automatic send_model(input logic [31:0] pc, input logic tk, input logic exp_acc, input bit sb);
    logic [3:0] b;
    b = 4'b0001 << mghr;
    send_upd(pc, tk, 1'b0, exp_acc, {pc[9:2], tk, b}, sb);
    if (exp_acc) mghr = {mghr[0], tk};
  endtask

  // Follow a clear walk of n writes from idx 0; optionally check the walk ending.
  task automatic clear_walk(input int n, input bit full_walk);
    int wt;
    for (wt = 0; wt < 20; wt++) begin
      if (upd_if.pr_wen && upd_if.pr_clr) break;
      @(negedge cpu_clk);
    end
    chk("clear_start", {31'b0, upd_if.pr_wen && upd_if.pr_clr}, 32'd1);
    for (int i = 0; i < n; i++) begin
      chk("clear_wr", {upd_if.pr_wen, upd_if.pr_clr, upd_if.pr_bank_sel, upd_if.pr_waddr},
          {1'b1, 1'b1, 4'b1111, 8'(i)});
      chk("clear_busy", {31'b0, upd_if.flush_busy}, 32'd1);
      if (i < 255) chk("clear_ready", {31'b0, upd_if.upd_ready}, 32'd0);
      if (i != n - 1) @(negedge cpu_clk);
    end
    if (full_walk) begin
      @(negedge cpu_clk);
      chk("walk_done_busy", {31'b0, upd_if.flush_busy}, 32'd0);
      chk("walk_done_ready", {31'b0, upd_if.upd_ready}, 32'd1);
      chk("walk_done_wen", {31'b0, upd_if.pr_wen}, 32'd0);
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 30 && sb_q.size() != 0; k++) @(negedge cpu_clk);
    @(negedge cpu_clk);
    chk("drain", sb_q.size(), 0);
  endtask

  initial begin
    vt[0] = '{32'h104,  1'b1, 1'b0, 8'h41, 4'b0001, 2'b01};
    vt[1] = '{32'h208,  1'b0, 1'b0, 8'h82, 4'b0010, 2'b10};
    vt[2] = '{32'h3FC,  1'b1, 1'b1, 8'h00, 4'b0000, 2'b10};
    vt[3] = '{32'h00C,  1'b1, 1'b0, 8'h03, 4'b0100, 2'b01};
    vt[4] = '{32'hFFF0, 1'b1, 1'b0, 8'hFC, 4'b0010, 2'b11};
    vt[5] = '{32'h400,  1'b0, 1'b0, 8'h00, 4'b1000, 2'b10};
    vt[6] = '{32'h007,  1'b1, 1'b0, 8'h01, 4'b0100, 2'b01};

    upd_if.upd_valid = 1'b0; upd_if.upd_is_loop = 1'b0; upd_if.upd_taken = 1'b0;
    upd_if.upd_pc = '0; upd_if.flush_req = 1'b0; upd_if.pr_wr_stall = 1'b0;

    // Reset state.
    repeat (3) @(negedge cpu_clk);
    chk("rst_wen", {31'b0, upd_if.pr_wen}, 32'd0);
    chk("rst_waddr_bank", {upd_if.pr_clr, upd_if.pr_wtaken, upd_if.pr_bank_sel, upd_if.pr_waddr}, 32'd0);
    chk("rst_busy", {31'b0, upd_if.flush_busy}, 32'd1);
    chk("rst_ghr_drop", {upd_if.ghr, upd_if.drop_cnt}, 32'd0);
    chk("rst_ready", {31'b0, upd_if.upd_ready}, 32'd0);
    cpu_rstn = 1'b1;

    // Post-reset clear walk.
    clear_walk(256, 1'b1);

    // Table vectors on consecutive cycles, including one loop branch.
    for (int i = 0; i < 7; i++) begin
      send_upd(vt[i].pc, vt[i].tk, vt[i].lp, 1'b1, {vt[i].addr, vt[i].tk, vt[i].bank}, 1'b1);
      chk("tbl_ghr", {30'b0, upd_if.ghr}, {30'b0, vt[i].ghr_after});
      mghr = vt[i].ghr_after;
    end
    wait_drain();
    chk("tbl_drop", {24'b0, upd_if.drop_cnt}, 32'd0);

    // Queue full under stall: 4 accepted, 2 dropped, then 4 back-to-back writes.
    upd_if.pr_wr_stall = 1'b1;
    for (int i = 0; i < 6; i++) send_model(32'h40 + 32'(i * 4), i[0], (i < 4), 1'b1);
    chk("full_drop", {24'b0, upd_if.drop_cnt}, mdrop);
    chk("full_ready", {31'b0, upd_if.upd_ready}, 32'd0);
    chk("full_wen", {31'b0, upd_if.pr_wen}, 32'd0);
    wr_cyc.delete();
    upd_if.pr_wr_stall = 1'b0;
    wait_drain();
    chk("burst_cnt", wr_cyc.size(), 4);
    if (wr_cyc.size() == 4) chk("burst_span", wr_cyc[3] - wr_cyc[0], 3);

    // Flush with entries queued: they vanish, ghr zeroes, walk restarts.
    upd_if.pr_wr_stall = 1'b1;
    for (int i = 0; i < 3; i++) send_model(32'h500 + 32'(i * 4), 1'b1, 1'b1, 1'b0);
    upd_if.pr_wr_stall = 1'b0;
    upd_if.flush_req = 1'b1;
    @(negedge cpu_clk);
    upd_if.flush_req = 1'b0;
    mghr = 2'b00;
    chk("flush_ghr", {30'b0, upd_if.ghr}, 32'd0);
    chk("flush_busy", {31'b0, upd_if.flush_busy}, 32'd1);
    chk("flush_ready", {31'b0, upd_if.upd_ready}, 32'd0);
    clear_walk(100, 1'b0);
    upd_if.flush_req = 1'b1;
    @(negedge cpu_clk);
    upd_if.flush_req = 1'b0;
    clear_walk(256, 1'b1);
    chk("post_flush_drop", {24'b0, upd_if.drop_cnt}, mdrop);

    // Drop counter saturation.
    upd_if.pr_wr_stall = 1'b1;
    for (int i = 0; i < 260; i++) send_model(32'h1000 + 32'(i * 4), i[0], (i < 4), 1'b1);
    chk("sat_drop", {24'b0, upd_if.drop_cnt}, 32'd255);
    send_model(32'h2000, 1'b1, 1'b0, 1'b1);
    chk("sat_hold", {24'b0, upd_if.drop_cnt}, 32'd255);
    chk("sat_ghr", {30'b0, upd_if.ghr}, {30'b0, mghr});
    upd_if.pr_wr_stall = 1'b0;
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout actual running required finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/predictor_upd_ctrl.md
Name: predictor_upd_ctrl

Overview:
Update scheduler for the 2-level 2-bit branch predictor.
- Accepts resolved-branch updates from EX and keeps the 2-bit global history register (GHR).
- Queues each update with its bank select in a small FIFO and drains it to the predictor write port one entry per cycle.
- Sequences a full-table clear walk after reset and on flush request.
- Sits between the EX stage and the four predictor banks, replacing their direct EX write enables.

Parameters:
ENTRY_NUM, 256, entries per predictor bank
PR_ADDR_WIDTH, $clog2(ENTRY_NUM), table index width
FIFO_DEPTH, 4, update queue depth (power of 2, ≥2)
CNT_WIDTH, 8, drop counter width

Ports:
cpu_clk  in  1  core clock
cpu_rstn  in  1  asynchronous active-low reset
upd_valid  in  1  single-cycle pulse: branch resolved in EX (never held or retried)
upd_is_loop  in  1  branch is a loop branch; excluded from predictor
upd_taken  in  1  resolved direction
upd_pc  in  `ADDR_WIDTH  branch PC
upd_ready  out  1  combinational: an update presented this cycle will be accepted
flush_req  in  1  pulse: clear all tables (fence.i / context switch)
pr_wr_stall  in  1  predictor write port is owned by another client this cycle
ghr  out  2  current global history, for read-side bank select
pr_wen  out  1  registered write strobe
pr_waddr  out  PR_ADDR_WIDTH  registered write index
pr_wtaken  out  1  registered update direction
pr_clr  out  1  registered: write is a clear (entry := weakly-not-taken 2'b01)
pr_bank_sel  out  4  registered one-hot bank select; 4'b1111 during clear
flush_busy  out  1  clear walk in progress
drop_cnt  out  CNT_WIDTH  saturating count of dropped non-loop updates

Behaviour:
- One clock, cpu_clk. Reset is asynchronous, active-low on cpu_rstn.
- Reset values:
  - State = CLEAR, clear index = 0, FIFO empty, ghr = 2'b00, drop_cnt = 0.
  - pr_wen, pr_clr, pr_wtaken = 0; pr_waddr = 0; pr_bank_sel = 0; flush_busy = 1.
- States: CLEAR, RUN.
- CLEAR state:
  - Each cycle pr_wr_stall=0: present pr_wen=1, pr_clr=1, pr_bank_sel=4'b1111, pr_waddr=idx, then idx++.
  - pr_wr_stall=1: no write that cycle; idx holds.
  - After the write of idx=ENTRY_NUM-1 → RUN. flush_busy is low from the next cycle.
  - upd_ready=0 throughout.
- RUN, accept rule:
  - upd_ready = (state==RUN) && !fifo_full. No enqueue/dequeue bypass when full.
  - On upd_valid && !upd_is_loop && upd_ready, enqueue {upd_pc[PR_ADDR_WIDTH+1:2], upd_taken, onehot(ghr)}, where ghr is the pre-update value.
  - Same cycle: ghr <= {ghr[0], upd_taken}.
  - Loop branches: always ignored. No enqueue, no ghr change, no drop count.
- Drop rule:
  - upd_valid && !upd_is_loop && !upd_ready → update discarded, ghr unchanged.
  - drop_cnt += 1, saturating at all-ones. drop_cnt is cleared only by reset.
- Drain:
  - In RUN, if FIFO non-empty && !pr_wr_stall, pop head.
  - Next cycle: pr_wen=1, pr_clr=0, pr_waddr/pr_wtaken/pr_bank_sel from the entry.
  - Otherwise pr_wen=0; pr_waddr/pr_wtaken/pr_bank_sel hold.
  - Enqueue and pop may occur in the same cycle. Minimum latency enqueue→pr_wen is 1 cycle.
- Bank select one-hot: ghr 00→0001, 01→0010, 10→0100, 11→1000.
- Flush:
  - flush_req in any state: FIFO emptied, ghr <= 2'b00, idx <= 0, state <= CLEAR, flush_busy <= 1, all next cycle.
  - A same-cycle upd_valid is dropped and counted. A same-cycle pop is cancelled, so no pr_wen next cycle except the clear write.
  - flush_req during CLEAR restarts the walk at 0.
- FIFO pointers are PR-independent: log2(FIFO_DEPTH)+1 bits with wrap bit. full/empty come from pointer compare.

Decomposition:
- Shared package/header core_defines.vh: `ADDR_WIDTH, the PR_CLR_VALUE 2'b01 constant, and the ghr→bank one-hot mapping as a shared function, also used by predictor_m2n2's read select.
- One sub-module: pr_upd_fifo. Synchronous FIFO with push, pop, flush, full, empty, data of width PR_ADDR_WIDTH+5, depth FIFO_DEPTH.
- FSM, ghr, drop counter and output registers stay in predictor_upd_ctrl.

Test Plan:
1. Reset release, no stall → pr_clr writes idx 0..255 on 256 consecutive cycles with bank_sel=1111. flush_busy falls the cycle after idx 255. upd_ready=0 throughout, then 1.
2. In RUN, ghr=00: updates pc=0x104 taken, then pc=0x208 not-taken on consecutive cycles → writes waddr=0x41 taken bank 0001, then waddr=0x82 not-taken bank 0010. ghr ends 2'b10.
3. upd_valid with upd_is_loop=1, taken → no pr_wen, ghr unchanged, drop_cnt unchanged.
4. Hold pr_wr_stall=1, send 6 non-loop updates → 4 enqueued, drop_cnt=2, upd_ready=0 after the 4th. Release stall → 4 writes on 4 consecutive cycles in order.
5. With 3 entries queued, pulse flush_req → no update writes appear. ghr=00, a full 256-entry clear follows. A flush_req at clear idx 100 restarts the walk at idx 0.
6. Send 260 updates with pr_wr_stall=1 → drop_cnt saturates at 255, stays 255.
